// File: rtl/mem_access_ctrl.sv
// EXE/MEM load/store controller: drives a req/ack data-memory bus with big-endian
// byte enables and lane-aligned store data, stalling the pipeline until the access completes.
module mem_access_ctrl #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_valid,
  input  logic [5:0]  i_instr_op,
  input  logic [31:0] i_addr,
  input  logic [31:0] i_reg_data,
  output logic        o_stall,
  output logic        o_done,
  output logic [31:0] o_rdata,
  output logic [1:0]  o_addr_lo,
  output logic [5:0]  o_op,
  output logic        o_addr_err,
  output logic        o_bus_err,
  output logic        o_mem_req,
  output logic        o_mem_we,
  output logic [31:0] o_mem_addr,
  output logic [3:0]  o_mem_be,
  output logic [31:0] o_mem_wdata,
  input  logic        i_mem_ack,
  input  logic [31:0] i_mem_rdata
);

  localparam logic [5:0] OP_LB  = 6'h20;
  localparam logic [5:0] OP_LH  = 6'h21;
  localparam logic [5:0] OP_LWL = 6'h22;
  localparam logic [5:0] OP_LW  = 6'h23;
  localparam logic [5:0] OP_LBU = 6'h24;
  localparam logic [5:0] OP_LHU = 6'h25;
  localparam logic [5:0] OP_LWR = 6'h26;
  localparam logic [5:0] OP_SB  = 6'h28;
  localparam logic [5:0] OP_SH  = 6'h29;
  localparam logic [5:0] OP_SWL = 6'h2A;
  localparam logic [5:0] OP_SW  = 6'h2B;
  localparam logic [5:0] OP_SWR = 6'h2E;

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_DONE} state_t;

  state_t      state_q;
  logic [15:0] cnt_q;
  logic        done_q, bus_err_q, req_q, we_q;
  logic [31:0] rdata_q, maddr_q, wdata_q;
  logic [1:0]  addr_lo_q;
  logic [5:0]  op_q;
  logic [3:0]  be_q;

  logic        is_mem, is_store, misal, accept;
  logic [1:0]  off;
  logic [3:0]  be_d;
  logic [31:0] wdata_d;

  assign off = i_addr[1:0];

  always_comb begin
    is_mem   = 1'b1;
    is_store = 1'b0;
    misal    = 1'b0;
    be_d     = 4'b1111;
    wdata_d  = '0;
    unique case (i_instr_op)
      OP_LB, OP_LBU, OP_LWL, OP_LWR: ;
      OP_LH, OP_LHU: misal = i_addr[0];
      OP_LW:         misal = |off;
      OP_SB: begin
        is_store = 1'b1;
        be_d     = 4'b1000 >> off;
        wdata_d  = {4{i_reg_data[7:0]}};
      end
      OP_SH: begin
        is_store = 1'b1;
        misal    = i_addr[0];
        be_d     = i_addr[1] ? 4'b0011 : 4'b1100;
        wdata_d  = {2{i_reg_data[15:0]}};
      end
      OP_SW: begin
        is_store = 1'b1;
        misal    = |off;
        wdata_d  = i_reg_data;
      end
      // SWL fills from the addressed byte to the word end; SWR from word start up to it.
      OP_SWL: begin
        is_store = 1'b1;
        be_d     = 4'b1111 >> off;
        wdata_d  = i_reg_data >> {off, 3'b000};
      end
      OP_SWR: begin
        is_store = 1'b1;
        be_d     = 4'b1111 << ~off;
        wdata_d  = i_reg_data << {~off, 3'b000};
      end
      default: is_mem = 1'b0;
    endcase
  end

  assign accept     = (state_q == S_IDLE) && i_valid && is_mem && !misal;
  assign o_stall    = accept || (state_q == S_REQ);
  assign o_addr_err = (state_q == S_IDLE) && i_valid && is_mem && misal;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      done_q    <= 1'b0;
      bus_err_q <= 1'b0;
      req_q     <= 1'b0;
      we_q      <= 1'b0;
      rdata_q   <= '0;
      maddr_q   <= '0;
      wdata_q   <= '0;
      be_q      <= '0;
      addr_lo_q <= '0;
      op_q      <= '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          done_q    <= 1'b0;
          bus_err_q <= 1'b0;
          if (accept) begin
            req_q     <= 1'b1;
            we_q      <= is_store;
            maddr_q   <= {i_addr[31:2], 2'b00};
            be_q      <= be_d;
            wdata_q   <= wdata_d;
            addr_lo_q <= off;
            op_q      <= i_instr_op;
            cnt_q     <= '0;
            state_q   <= S_REQ;
          end
        end
        S_REQ: begin
          // Ack is tested first so an ack on the final timeout cycle still completes cleanly.
          if (i_mem_ack) begin
            req_q   <= 1'b0;
            rdata_q <= we_q ? '0 : i_mem_rdata;
            done_q  <= 1'b1;
            state_q <= S_DONE;
          end else if (cnt_q == 16'(TIMEOUT - 1)) begin
            req_q     <= 1'b0;
            rdata_q   <= '0;
            bus_err_q <= 1'b1;
            done_q    <= 1'b1;
            state_q   <= S_DONE;
          end else begin
            cnt_q <= cnt_q + 16'd1;
          end
        end
        S_DONE: begin
          done_q    <= 1'b0;
          bus_err_q <= 1'b0;
          state_q   <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign o_done      = done_q;
  assign o_bus_err   = bus_err_q;
  assign o_rdata     = rdata_q;
  assign o_addr_lo   = addr_lo_q;
  assign o_op        = op_q;
  assign o_mem_req   = req_q;
  assign o_mem_we    = we_q;
  assign o_mem_addr  = maddr_q;
  assign o_mem_be    = be_q;
  assign o_mem_wdata = wdata_q;

endmodule
